// File: rtl/data_mem_responder_pkg.sv
// Shared constants and types for the data memory responder.
// Provides the word/address widths, counter width and FSM state type.
package data_mem_responder_pkg;

   localparam int WORD_SIZE = 19;
   localparam int ADDR_SIZE = 11;
   localparam int CNT_W     = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } resp_state_t;

endpackage

// File: rtl/data_mem_responder_mem_array.sv
// Single-port storage: synchronous write, registered read.
// Ports: clk, clear (zeroes read register only), en, write,
//        addr (word index), wdata, rdata (registered read data).
module mem_array
   import data_mem_responder_pkg::*;
#(
   parameter int DEPTH = 1024,
   parameter int AW    = 10
) (
   input  logic                 clk,
   input  logic                 clear,
   input  logic                 en,
   input  logic                 write,
   input  logic [AW-1:0]        addr,
   input  logic [WORD_SIZE-1:0] wdata,
   output logic [WORD_SIZE-1:0] rdata
);

   // Contents are deliberately not reset so they survive reset.
   logic [WORD_SIZE-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (en && write) begin
         mem[addr] <= wdata;
      end
   end

   // The read register is held at zero outside a read response.
   always_ff @(posedge clk) begin
      if (clear) begin
         rdata <= '0;
      end else if (en && !write) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/data_mem_responder.sv
// Valid/ready memory responder with fixed wait states.
// Ports: clk, reset (sync, active high); request channel
//        req_valid/req_ready/req_write/req_addr/req_wdata;
//        response channel rsp_valid/rsp_ready/rsp_rdata/rsp_err.
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter int DEPTH       = 1024,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_write,
   input  logic [ADDR_SIZE-1:0] req_addr,
   input  logic [WORD_SIZE-1:0] req_wdata,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [WORD_SIZE-1:0] rsp_rdata,
   output logic                 rsp_err
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam bit NO_WAIT = (WAIT_CYCLES == 0);
   localparam logic [CNT_W-1:0] CNT_INIT =
      CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
   // One extra bit so DEPTH == 2**ADDR_SIZE stays representable.
   localparam logic [ADDR_SIZE:0] DEPTH_W = (ADDR_SIZE+1)'(DEPTH);

   resp_state_t state;
   resp_state_t state_next;

   logic [CNT_W-1:0]     cnt;
   logic                 lat_write;
   logic [ADDR_SIZE-1:0] lat_addr;
   logic [WORD_SIZE-1:0] lat_wdata;

   logic                 accept;
   logic                 enter_resp;
   logic                 consume;
   logic                 eff_write;
   logic [ADDR_SIZE-1:0] eff_addr;
   logic [WORD_SIZE-1:0] eff_wdata;
   logic                 in_range;
   logic                 mem_en;
   logic                 mem_clear;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // With no wait states the memory is accessed on the
   // acceptance edge itself, so the live request is used.
   always_comb begin
      state_next = state;
      req_ready  = 1'b0;
      accept     = 1'b0;
      enter_resp = 1'b0;
      consume    = 1'b0;
      eff_write  = lat_write;
      eff_addr   = lat_addr;
      eff_wdata  = lat_wdata;
      unique case (state)
         IDLE: begin
            req_ready = 1'b1;
            accept    = req_valid;
            eff_write = req_write;
            eff_addr  = req_addr;
            eff_wdata = req_wdata;
            if (req_valid) begin
               state_next = NO_WAIT ? RESP : BUSY;
               enter_resp = NO_WAIT;
            end
         end
         BUSY: begin
            if (cnt == '0) begin
               state_next = RESP;
               enter_resp = 1'b1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_next = IDLE;
               consume    = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign in_range  = {1'b0, eff_addr} < DEPTH_W;
   assign mem_en    = enter_resp && in_range && !reset;
   assign mem_clear = reset || consume;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt       <= '0;
         lat_write <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
      end else begin
         if (accept) begin
            cnt       <= CNT_INIT;
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
         end else if (state == BUSY && cnt != '0) begin
            cnt <= cnt - 1'b1;
         end
         if (enter_resp) begin
            rsp_valid <= 1'b1;
            rsp_err   <= !in_range;
         end else if (consume) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
         end
      end
   end

   mem_array #(
      .DEPTH (DEPTH),
      .AW    (IDX_W)
   ) u_mem (
      .clk   (clk),
      .clear (mem_clear),
      .en    (mem_en),
      .write (eff_write),
      .addr  (eff_addr[IDX_W-1:0]),
      .wdata (eff_wdata),
      .rdata (rsp_rdata)
   );

endmodule
